// File: rtl/sram_resp.sv
// sram_resp: 64 x 128-bit word store with acked read/write, 8-word block clear (INIT) and block
// stream (DUMP). Define SRAM_RESP_ADDR_CHECK_EN to reject accesses with sramAddr >= 64.
module sram_resp (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         sramRead,
    input  logic         sramWrite,
    input  logic [15:0]  sramAddr,
    input  logic [127:0] sramWriteValue,
    input  logic         sramInit,
    input  logic [2:0]   sramInitNum,
    input  logic         sramDump,
    input  logic [2:0]   sramDumpNum,
    output logic [127:0] sramReadValue,
    output logic         sramReady,
    output logic         busy,
    output logic         dumpValid,
    output logic [127:0] dumpData,
    output logic [2:0]   dumpIdx,
    output logic         addrErr
);

    typedef enum logic [1:0] {StIdle, StInit, StDump} stateT;

    stateT        state;
    logic [2:0]   beat;
    logic [2:0]   blockNum;
    logic [2:0]   nextBeat;
    logic [5:0]   wordAddr;
    logic         addrBad;
    logic [127:0] mem [64];

    assign wordAddr = sramAddr[5:0];
    assign nextBeat = beat + 3'd1;

`ifdef SRAM_RESP_ADDR_CHECK_EN
    assign addrBad = |sramAddr[15:6];
`else
    // Upper address bits are ignored: addresses alias onto the 64 implemented words.
    logic [9:0] unusedAddrHi;
    assign unusedAddrHi = sramAddr[15:6];
    assign addrBad      = 1'b0;
`endif

    // Memory shares the block but is never touched by reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state         <= StIdle;
            beat          <= 3'd0;
            blockNum      <= 3'd0;
            sramReadValue <= '0;
            sramReady     <= 1'b0;
            busy          <= 1'b0;
            dumpValid     <= 1'b0;
            dumpData      <= '0;
            dumpIdx       <= 3'd0;
            addrErr       <= 1'b0;
        end else begin
            sramReady <= 1'b0;
            addrErr   <= 1'b0;
            case (state)
                StIdle: begin
                    if (sramInit) begin
                        state    <= StInit;
                        blockNum <= sramInitNum;
                        beat     <= 3'd0;
                        busy     <= 1'b1;
                    end else if (sramDump) begin
                        state     <= StDump;
                        blockNum  <= sramDumpNum;
                        beat      <= 3'd0;
                        busy      <= 1'b1;
                        dumpValid <= 1'b1;
                        dumpIdx   <= 3'd0;
                        dumpData  <= mem[{sramDumpNum, 3'd0}];
                    end else if (sramWrite) begin
                        if (!addrBad) begin
                            mem[wordAddr] <= sramWriteValue;
                        end
                        sramReady <= 1'b1;
                        addrErr   <= addrBad;
                    end else if (sramRead) begin
                        sramReadValue <= addrBad ? '0 : mem[wordAddr];
                        sramReady     <= 1'b1;
                        addrErr       <= addrBad;
                    end
                end
                StInit: begin
                    mem[{blockNum, beat}] <= '0;
                    beat                  <= nextBeat;
                    if (beat == 3'd7) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                StDump: begin
                    beat <= nextBeat;
                    if (beat == 3'd7) begin
                        state     <= StIdle;
                        busy      <= 1'b0;
                        dumpValid <= 1'b0;
                        dumpData  <= '0;
                        dumpIdx   <= 3'd0;
                    end else begin
                        dumpIdx  <= nextBeat;
                        dumpData <= mem[{blockNum, nextBeat}];
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_resp.sv
// Scoreboard bench for sram_resp: stimulus pushes expected acks/beats, a negedge monitor pops them.
module tb_sram_resp;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         sramRead = 1'b0;
    logic         sramWrite = 1'b0;
    logic [15:0]  sramAddr = '0;
    logic [127:0] sramWriteValue = '0;
    logic         sramInit = 1'b0;
    logic [2:0]   sramInitNum = '0;
    logic         sramDump = 1'b0;
    logic [2:0]   sramDumpNum = '0;
    logic [127:0] sramReadValue;
    logic         sramReady;
    logic         busy;
    logic         dumpValid;
    logic [127:0] dumpData;
    logic [2:0]   dumpIdx;
    logic         addrErr;

    sram_resp dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .sramRead       (sramRead),
        .sramWrite      (sramWrite),
        .sramAddr       (sramAddr),
        .sramWriteValue (sramWriteValue),
        .sramInit       (sramInit),
        .sramInitNum    (sramInitNum),
        .sramDump       (sramDump),
        .sramDumpNum    (sramDumpNum),
        .sramReadValue  (sramReadValue),
        .sramReady      (sramReady),
        .busy           (busy),
        .dumpValid      (dumpValid),
        .dumpData       (dumpData),
        .dumpIdx        (dumpIdx),
        .addrErr        (addrErr)
    );

    always #5 clk = ~clk;

`ifdef SRAM_RESP_ADDR_CHECK_EN
    localparam bit AddrCheck = 1'b1;
`else
    localparam bit AddrCheck = 1'b0;
`endif

    typedef struct packed {
        logic         isDump;
        logic [127:0] data;
        logic [2:0]   idx;
        logic         err;
    } expT;

    expT          expQ[$];
    expT          mon;
    logic [127:0] model [64];
    logic [127:0] lastRead = '0;
    int           checks = 0;
    int           failures = 0;
    bit           monOn = 1'b0;

    localparam logic [127:0] KVal = 128'h112233445566778899AABBCCDDEEFF00;
    localparam logic [127:0] VVal = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
    localparam logic [127:0] ZVal = 128'h0F0F0F0F_F0F0F0F0_55555555_AAAAAAAA;
    localparam logic [127:0] WVal = 128'h99999999_88888888_77777777_66666666;

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic logic isBad(input logic [15:0] a);
        return AddrCheck && (a >= 16'd64);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doWrite(input logic [15:0] a, input logic [127:0] v);
        expT e;
        e.isDump = 1'b0;
        e.data   = lastRead;
        e.idx    = 3'd0;
        e.err    = isBad(a);
        expQ.push_back(e);
        if (!isBad(a)) model[a[5:0]] = v;
        sramWrite      = 1'b1;
        sramAddr       = a;
        sramWriteValue = v;
        tick();
        sramWrite = 1'b0;
    endtask

    task automatic doRead(input logic [15:0] a);
        expT e;
        e.isDump = 1'b0;
        e.data   = isBad(a) ? '0 : model[a[5:0]];
        e.idx    = 3'd0;
        e.err    = isBad(a);
        lastRead = e.data;
        expQ.push_back(e);
        sramRead = 1'b1;
        sramAddr = a;
        tick();
        sramRead = 1'b0;
    endtask

    task automatic doDump(input logic [2:0] num, input int beats);
        expT e;
        for (int i = 0; i < beats; i++) begin
            e.isDump = 1'b1;
            e.data   = model[{num, 3'(i)}];
            e.idx    = 3'(i);
            e.err    = 1'b0;
            expQ.push_back(e);
        end
        sramDump    = 1'b1;
        sramDumpNum = num;
        tick();
        sramDump = 1'b0;
    endtask

    task automatic doInit(input logic [2:0] num);
        for (int i = 0; i < 8; i++) model[{num, 3'(i)}] = '0;
        sramInit    = 1'b1;
        sramInitNum = num;
        tick();
        sramInit = 1'b0;
    endtask

    // Busy must cover exactly 8 cycles; a read held throughout must never be acked.
    task automatic busyWindow(input string name);
        sramRead = 1'b1;
        sramAddr = 16'd32;
        for (int i = 0; i < 8; i++) begin
            chk({name, "_busy_high"}, 128'(busy), 128'(1));
            tick();
        end
        sramRead = 1'b0;
        chk({name, "_busy_low"}, 128'(busy), 128'(0));
    endtask

    always @(negedge clk) begin
        if (monOn) begin
            if (sramReady || dumpValid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_response ready=%0b dumpValid=%0b required=none",
                             sramReady, dumpValid);
                end else begin
                    mon = expQ.pop_front();
                    if (mon.isDump) begin
                        chk("dump_valid", 128'(dumpValid), 128'(1));
                        chk("dump_data", dumpData, mon.data);
                        chk("dump_idx", 128'(dumpIdx), 128'(mon.idx));
                    end else begin
                        chk("ready", 128'(sramReady), 128'(1));
                        chk("read_value", sramReadValue, mon.data);
                        chk("addr_err", 128'(addrErr), 128'(mon.err));
                    end
                end
            end else begin
                chk("dump_data_idle", dumpData, '0);
                chk("addr_err_idle", 128'(addrErr), 128'(0));
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (3) tick();
        chk("rst_read_value", sramReadValue, '0);
        chk("rst_ready", 128'(sramReady), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_dump_valid", 128'(dumpValid), 128'(0));
        chk("rst_dump_data", dumpData, '0);
        chk("rst_dump_idx", 128'(dumpIdx), 128'(0));
        chk("rst_addr_err", 128'(addrErr), 128'(0));
        n_rst = 1'b1;
        monOn = 1'b1;
        tick();

        // Write then read on consecutive edges returns the new data.
        doWrite(16'd32, KVal);
        doRead(16'd32);

        for (int i = 40; i < 48; i++) doWrite(16'(i), 128'(i));
        doDump(3'd5, 8);
        busyWindow("dump");
        doRead(16'd40);

        doInit(3'd4);
        busyWindow("init");
        doRead(16'd32);
        doRead(16'd40);

        // Simultaneous write+read: write wins, single ack, read value unchanged.
        begin
            expT e;
            e.isDump = 1'b0;
            e.data   = lastRead;
            e.idx    = 3'd0;
            e.err    = 1'b0;
            expQ.push_back(e);
            model[10]      = VVal;
            sramWrite      = 1'b1;
            sramRead       = 1'b1;
            sramAddr       = 16'd10;
            sramWriteValue = VVal;
            tick();
            sramWrite = 1'b0;
            sramRead  = 1'b0;
        end
        doRead(16'd10);

        // Init outranks a same-cycle read.
        sramRead = 1'b1;
        sramAddr = 16'd10;
        doInit(3'd7);
        busyWindow("init_prio");

        // Reset during dump beat 3.
        doDump(3'd5, 4);
        repeat (3) tick();
        n_rst = 1'b0;
        tick();
        chk("rstdump_valid", 128'(dumpValid), 128'(0));
        chk("rstdump_busy", 128'(busy), 128'(0));
        chk("rstdump_data", dumpData, '0);
        chk("rstdump_read_value", sramReadValue, '0);
        n_rst    = 1'b1;
        lastRead = '0;
        doRead(16'd43);
        doRead(16'd32);

        // Out-of-range address: rejected with error, or aliased onto word 0.
        doWrite(16'd0, ZVal);
        doWrite(16'd64, WVal);
        doRead(16'd0);
        if (AddrCheck) doRead(16'd64);

        repeat (4) tick();
        chk("queue_empty", 128'(expQ.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_resp.md
SRAM_RESP -- requirements
Module: sram_resp

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low; ports clk and n_rst.
REQ-002 SHALL provide port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port: n_rst  input  1  synchronous active-low reset.
REQ-004 SHALL provide port: sramRead  input  1  read request for sramAddr.
REQ-005 SHALL provide port: sramWrite  input  1  write request of sramWriteValue to sramAddr.
REQ-006 SHALL provide port: sramAddr  input  16  word address; 64 words implemented (0..63).
REQ-007 SHALL provide port: sramWriteValue  input  128  write data.
REQ-008 SHALL provide port: sramInit  input  1  clear-block request.
REQ-009 SHALL provide port: sramInitNum  input  3  block to clear (block N = words 8N..8N+7).
REQ-010 SHALL provide port: sramDump  input  1  stream-block request.
REQ-011 SHALL provide port: sramDumpNum  input  3  block to stream.
REQ-012 SHALL provide port: sramReadValue  output  128  registered read data, held until next accepted read.
REQ-013 SHALL provide port: sramReady  output  1  one-cycle ack of an accepted read or write.
REQ-014 SHALL provide port: busy  output  1  high while INIT or DUMP in progress.
REQ-015 SHALL provide port: dumpValid  output  1  dumpData/dumpIdx valid this cycle.
REQ-016 SHALL provide port: dumpData  output  128  streamed word.
REQ-017 SHALL provide port: dumpIdx  output  3  word index within streamed block.
REQ-018 SHALL provide port: addrErr  output  1  one-cycle out-of-range pulse (see Configuration).

Function
REQ-019 SHALL implement FSM states IDLE, INIT, DUMP; requests sampled only in IDLE, ignored (no ack) otherwise.
REQ-020 SHALL, in IDLE, apply priority sramInit > sramDump > sramWrite > sramRead per edge; lower requests that cycle are dropped without ack.
REQ-021 SHALL commit an accepted write at the sampling edge and pulse sramReady in the following cycle.
REQ-022 SHALL, for an accepted read at edge k, drive sramReadValue = mem[addr] and sramReady=1 in cycle k+1 (latency 1); read-after-write to same address on consecutive edges returns new data.
REQ-023 SHALL, on accepted init, enter INIT: clear words 8N..8N+7 to zero, one per cycle ascending, 8 cycles, busy=1 throughout, then IDLE.
REQ-024 SHALL, on accepted dump, enter DUMP: dumpValid=1 for 8 consecutive cycles starting next cycle, dumpIdx=0..7, dumpData=mem[8N+dumpIdx], busy=1, then IDLE.
REQ-025 SHALL deassert busy in the first IDLE cycle after the 8th INIT/DUMP beat; a request present that cycle is accepted.
REQ-026 SHALL leave dumpData at zero when dumpValid=0.

Reset
REQ-027 SHALL, while n_rst=0 at a clock edge, force IDLE and zero sramReadValue, sramReady, busy, dumpValid, dumpData, dumpIdx, addrErr.
REQ-028 SHALL abort INIT/DUMP on reset mid-operation; words already cleared stay cleared, remaining words untouched.
REQ-029 SHALL NOT clear memory contents on reset; power-up contents undefined.

Configuration
REQ-030 SHALL, with SRAM_RESP_ADDR_CHECK_EN defined, treat sramAddr>=64 on an accepted read/write as error: write dropped, read returns 0, sramReady and addrErr pulse together in cycle k+1.
REQ-031 SHALL, without SRAM_RESP_ADDR_CHECK_EN, tie addrErr to 0 and alias addresses via sramAddr[5:0].

Verification
REQ-032 SHALL cover: write 128'h112233445566778899AABBCCDDEEFF00 to addr 32, read addr 32 -> sramReadValue equals it one cycle later with sramReady=1.
REQ-033 SHALL cover: write words 40..47 = 40..47, sramDump with sramDumpNum=5 -> 8 beats, dumpIdx 0..7, dumpData 40..47, busy high 8 cycles.
REQ-034 SHALL cover: sramInit with sramInitNum=4 then read addr 32 -> 0; read addr 40 (block 5) unchanged.
REQ-035 SHALL cover: sramWrite and sramRead same cycle -> write committed, single sramReady, sramReadValue unchanged; read during busy -> no ack.
REQ-036 SHALL cover: n_rst low at DUMP beat 3 -> dumpValid/busy 0 next edge, IDLE; memory intact.
REQ-037 SHALL cover: with SRAM_RESP_ADDR_CHECK_EN, write addr 64 -> addrErr pulse, addr 0 unchanged; without it, write addr 64 lands in addr 0.
